halfband_interp_mac_n: RTL and testbench
========================================

Name: halfband_interp_mac_n

Overview:
- Parametrised successor to the team's 2-phase halfband interpolator. Interpolates by 2 with a symmetric halfband filter of 4*NUM_PAIRS-1 taps.
- The odd (non-centre) polyphase branch uses one time-shared multiplier: a pre-added tap pair per clk, accumulated.
- The even branch is the centre tap (x/2).
- Adds runtime coefficient load with a shadow bank, bypass/mute modes, output saturation, and overrun detection.
- Sits between the pulse-shaping/upsampling stage and the DAC path. Runs on the system clk under sample (sam_clk_en) and 2x-rate (bit_rate_en) enables.

Parameters:
- DATA_W, 18, sample width, signed 1s(DATA_W-1).
- COEF_W, 18, coefficient width, signed 0s(COEF_W).
- NUM_PAIRS, 2, number of symmetric non-centre coefficient pairs (>=1). Delay line length is 2*NUM_PAIRS.
- ADDR_W, 1, coefficient address width, >= clog2(NUM_PAIRS).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- sam_clk_en  in  1  input-sample-rate enable, one clk wide
- bit_rate_en  in  1  output-rate (2x sample) enable, one clk wide, coincident with sam_clk_en every second pulse
- x_in  in  DATA_W  input sample, 1s17
- mode  in  2  00 filter, 01 zero-stuff bypass, 10 sample-hold bypass, 11 mute
- coef_wr_en  in  1  write coef_data into shadow bank
- coef_addr  in  ADDR_W  pair index k; 0 = pair nearest centre
- coef_data  in  COEF_W  coefficient h[k], 0s18
- y  out  DATA_W  interpolated output, 1s17
- y_valid  out  1  one-clk pulse when y updates
- busy  out  1  MAC sequence in progress
- overrun  out  1  sticky: sam_clk_en arrived while busy
- sat  out  1  sticky: last or any filter result saturated

Behaviour:
- Reset (async): delay line, both coefficient banks, acc, result register, y, y_valid, busy, overrun, sat all 0; phase = 0; FSM = IDLE.
- Delay line x[0..2*NUM_PAIRS-1]: on sam_clk_en, x[0] <= x_in and x[i] <= x[i-1]. Otherwise hold.
- Coefficients:
  - coef_wr_en writes shadow[coef_addr] in that clk. Addresses >= NUM_PAIRS are ignored.
  - The active bank is loaded from shadow on sam_clk_en, so a MAC never mixes banks.
  - A write and sam_clk_en in the same clk: the write lands in shadow and is active from the next sample.
- Pre-add for pair k: p[k] = (x[NUM_PAIRS-1-k] >>> 1) + (x[NUM_PAIRS+k] >>> 1), in 2s16 format with no overflow.
- Centre: c = x[NUM_PAIRS] >>> 1.
- FSM IDLE -> MAC -> DONE -> IDLE:
  - sam_clk_en moves the FSM to MAC with k=0 and acc cleared; busy=1.
  - MAC: each clk, acc += h[k]*p[k] and k increments. After k=NUM_PAIRS-1 go to DONE.
  - DONE (1 clk): result <= sat(acc); busy=0; go to IDLE.
  - Latency from sam_clk_en to result valid: NUM_PAIRS+1 clk.
- Accumulator width: DATA_W+COEF_W+clog2(NUM_PAIRS)+1.
- Result is acc bits [DATA_W+COEF_W-2 -: DATA_W]. If the bits above that window are not a sign extension, clamp to +2^(DATA_W-1)-1 or -2^(DATA_W-1) and set sat (sticky, cleared only by reset).
- Overrun: sam_clk_en while busy aborts the running MAC, restarts it on the new sample, and sets overrun (sticky). result is not updated by the aborted run.
- Output phase:
  - sam_clk_en forces phase to 0 (same clk).
  - On each bit_rate_en: y is registered by mode and phase, y_valid=1 for that clk, and phase toggles.
  - mode 00: phase0 y <= c; phase1 y <= result.
  - mode 01: phase0 y <= x[NUM_PAIRS]; phase1 y <= 0.
  - mode 10: both phases y <= x[NUM_PAIRS].
  - mode 11: y <= 0.
- Integration requirement: the gap between bit_rate_en pulses must be >= NUM_PAIRS+2 clk, so result is ready before the phase-1 bit_rate_en.
- mode is sampled at bit_rate_en only. Changing mode takes effect on the next output.
- Reset mid-MAC: async clear as above, with no stale y_valid.

Test Plan:
- NUM_PAIRS=2, write h0=74920, h1=-9220, mode 00, bit_rate_en every 4 clk. Impulse x_in=65536 followed by zeros. Required (phase0, phase1) pairs per sample: (0,-2305), (0,18730), (32768,18730), (0,-2305), (0,0). sat=0, overrun=0.
- Same coefficients, DC x_in=131071, h0=h1=131071. Required: phase1 y=131071 (clamped) and sat=1. Then DC x_in=-131072: phase1 y=-131072.
- Rewrite h0=0 mid-MAC (between sam_clk_en pulses). Required: current sample's phase1 is unchanged; the next sample uses the new value.
- Modes with x_in=1000 constant: mode 01 gives y=1000, 0 alternating; mode 10 gives 1000, 1000; mode 11 gives 0, 0. Each output has a y_valid pulse.
- sam_clk_en 2 clk apart with NUM_PAIRS=2. Required: overrun=1, busy stays high, and the earlier result is not overwritten by the aborted run.
- Assert reset during MAC state. Required: y=0, busy=0, overrun=0, sat=0, coefficients=0 immediately (async). The first post-reset impulse reproduces scenario 1 after reloading coefficients.

Source files
------------

// File: rtl/halfband_interp_mac_n.sv
// 2x halfband interpolator: the even phase is the centre tap (x/2), and the odd phase is a time-shared
// pre-add MAC over the symmetric pairs. Includes a shadow/active coefficient bank, bypass/mute modes,
// a saturating result, and sticky overrun/sat flags.
module halfband_interp_mac_n #(
    parameter int DATA_W    = 18,
    parameter int COEF_W    = 18,
    parameter int NUM_PAIRS = 2,
    parameter int ADDR_W    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sam_clk_en,
    input  logic              bit_rate_en,
    input  logic [DATA_W-1:0] x_in,
    input  logic [1:0]        mode,
    input  logic              coef_wr_en,
    input  logic [ADDR_W-1:0] coef_addr,
    input  logic [COEF_W-1:0] coef_data,
    output logic [DATA_W-1:0] y,
    output logic              y_valid,
    output logic              busy,
    output logic              overrun,
    output logic              sat
);

    localparam int TAPS    = 2 * NUM_PAIRS;
    localparam int PROD_W  = DATA_W + COEF_W;
    localparam int ACC_W   = DATA_W + COEF_W + $clog2(NUM_PAIRS) + 1;
    localparam int RES_LSB = COEF_W - 1;
    localparam int HI_W    = ACC_W - RES_LSB;
    localparam int TOP_W   = HI_W - DATA_W + 1;
    localparam logic [ADDR_W-1:0]        K_LAST = ADDR_W'(NUM_PAIRS - 1);
    localparam logic signed [DATA_W-1:0] Y_MAX  = {1'b0, {(DATA_W-1){1'b1}}};
    localparam logic signed [DATA_W-1:0] Y_MIN  = {1'b1, {(DATA_W-1){1'b0}}};
    localparam logic signed [DATA_W-1:0] Y_ZERO = {DATA_W{1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAC  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // hi is the accumulator from the result LSB upward; returns {saturated, clamped result}.
    function automatic logic [DATA_W:0] sat_result(input logic [HI_W-1:0] hi);
        logic [TOP_W-1:0] top;
        top = hi[HI_W-1:DATA_W-1];
        if ((top == {TOP_W{1'b0}}) || (top == {TOP_W{1'b1}})) begin
            sat_result = {1'b0, hi[DATA_W-1:0]};
        end else if (hi[HI_W-1]) begin
            sat_result = {1'b1, Y_MIN};
        end else begin
            sat_result = {1'b1, Y_MAX};
        end
    endfunction

    logic signed [DATA_W-1:0] x_q      [TAPS];
    logic signed [DATA_W-1:0] x_d      [TAPS];
    logic signed [COEF_W-1:0] shadow_q [NUM_PAIRS];
    logic signed [COEF_W-1:0] shadow_d [NUM_PAIRS];
    logic signed [COEF_W-1:0] active_q [NUM_PAIRS];
    logic signed [COEF_W-1:0] active_d [NUM_PAIRS];
    state_t                   state_q, state_d;
    logic [ADDR_W-1:0]        k_q, k_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [DATA_W-1:0] result_q, result_d;
    logic signed [DATA_W-1:0] y_q, y_d;
    logic                     y_valid_q, y_valid_d;
    logic                     busy_q, busy_d;
    logic                     overrun_q, overrun_d;
    logic                     sat_q, sat_d;
    logic                     phase_q, phase_d;

    logic signed [DATA_W-1:0] pre_s [NUM_PAIRS];
    logic signed [DATA_W-1:0] pre_sel_s;
    logic signed [COEF_W-1:0] coef_sel_s;
    logic signed [PROD_W-1:0] prod_s;
    logic [DATA_W:0]          sat_res_s;
    logic signed [DATA_W-1:0] centre_s;
    logic                     phase_eff_s;

    // Pre-add every symmetric pair and select the pair and coefficient for the current MAC step.
    always_comb begin
        pre_sel_s  = Y_ZERO;
        coef_sel_s = {COEF_W{1'b0}};
        for (int i = 0; i < NUM_PAIRS; i++) begin
            pre_s[i]   = (x_q[NUM_PAIRS-1-i] >>> 1) + (x_q[NUM_PAIRS+i] >>> 1);
            pre_sel_s  = pre_sel_s | ((k_q == ADDR_W'(i)) ? pre_s[i] : Y_ZERO);
            coef_sel_s = coef_sel_s | ((k_q == ADDR_W'(i)) ? active_q[i] : {COEF_W{1'b0}});
        end
        prod_s    = coef_sel_s * pre_sel_s;
        sat_res_s = sat_result(acc_q[ACC_W-1:RES_LSB]);
    end

    // Next-state logic for the delay line, coefficient banks, MAC sequencer and output phase.
    always_comb begin
        x_d         = x_q;
        shadow_d    = shadow_q;
        active_d    = active_q;
        state_d     = state_q;
        k_d         = k_q;
        acc_d       = acc_q;
        result_d    = result_q;
        y_d         = y_q;
        y_valid_d   = 1'b0;
        busy_d      = busy_q;
        overrun_d   = overrun_q;
        sat_d       = sat_q;
        phase_d     = phase_q;
        phase_eff_s = phase_q;

        if (sam_clk_en) begin
            x_d[0] = x_in;
            for (int i = 1; i < TAPS; i++) begin
                x_d[i] = x_q[i-1];
            end
            active_d    = shadow_q;
            phase_eff_s = 1'b0;
        end else begin
            phase_eff_s = phase_q;
        end

        // A write in the same clk as sam_clk_en misses this copy, so it becomes active one sample later.
        for (int i = 0; i < NUM_PAIRS; i++) begin
            if (coef_wr_en && (coef_addr == ADDR_W'(i))) begin
                shadow_d[i] = coef_data;
            end else begin
                shadow_d[i] = shadow_q[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (sam_clk_en) begin
                    state_d = ST_MAC;
                    k_d     = {ADDR_W{1'b0}};
                    acc_d   = {ACC_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_MAC: begin
                if (sam_clk_en) begin
                    overrun_d = 1'b1;
                    k_d       = {ADDR_W{1'b0}};
                    acc_d     = {ACC_W{1'b0}};
                    busy_d    = 1'b1;
                end else if (k_q == K_LAST) begin
                    acc_d   = acc_q + ACC_W'(prod_s);
                    k_d     = {ADDR_W{1'b0}};
                    state_d = ST_DONE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d = acc_q + ACC_W'(prod_s);
                    k_d   = k_q + ADDR_W'(1);
                end
            end
            ST_DONE: begin
                result_d = sat_res_s[DATA_W-1:0];
                sat_d    = sat_q | sat_res_s[DATA_W];
                if (sam_clk_en) begin
                    state_d = ST_MAC;
                    k_d     = {ADDR_W{1'b0}};
                    acc_d   = {ACC_W{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // The even phase sees the sample shifted in this same clk, hence x_d rather than x_q.
        centre_s = x_d[NUM_PAIRS] >>> 1;
        if (bit_rate_en) begin
            y_valid_d = 1'b1;
            phase_d   = ~phase_eff_s;
            case (mode)
                2'b00:   y_d = phase_eff_s ? result_q : centre_s;
                2'b01:   y_d = phase_eff_s ? Y_ZERO : x_d[NUM_PAIRS];
                2'b10:   y_d = x_d[NUM_PAIRS];
                2'b11:   y_d = Y_ZERO;
                default: y_d = Y_ZERO;
            endcase
        end else begin
            phase_d = phase_eff_s;
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < TAPS; i++) begin
                x_q[i] <= {DATA_W{1'b0}};
            end
            for (int i = 0; i < NUM_PAIRS; i++) begin
                shadow_q[i] <= {COEF_W{1'b0}};
                active_q[i] <= {COEF_W{1'b0}};
            end
            state_q   <= ST_IDLE;
            k_q       <= {ADDR_W{1'b0}};
            acc_q     <= {ACC_W{1'b0}};
            result_q  <= {DATA_W{1'b0}};
            y_q       <= {DATA_W{1'b0}};
            y_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            overrun_q <= 1'b0;
            sat_q     <= 1'b0;
            phase_q   <= 1'b0;
        end else begin
            x_q       <= x_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            state_q   <= state_d;
            k_q       <= k_d;
            acc_q     <= acc_d;
            result_q  <= result_d;
            y_q       <= y_d;
            y_valid_q <= y_valid_d;
            busy_q    <= busy_d;
            overrun_q <= overrun_d;
            sat_q     <= sat_d;
            phase_q   <= phase_d;
        end
    end

    assign y       = y_q;
    assign y_valid = y_valid_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;
    assign sat     = sat_q;

endmodule

// File: tb/tb_halfband_interp_mac_n.sv
// Self-checking bench for halfband_interp_mac_n: a sample-level reference model with per-cycle
// comparison, plus directed scenarios with literal expected outputs and a randomized run.
module tb_halfband_interp_mac_n;

    localparam int DW = 18;
    localparam int CW = 18;
    localparam int NP = 2;
    localparam int AW = 1;
    localparam int YMAX = 2**(DW-1) - 1;
    localparam int YMIN = -(2**(DW-1));

    logic          clk = 1'b0;
    logic          reset;
    logic          sam_clk_en;
    logic          bit_rate_en;
    logic [DW-1:0] x_in;
    logic [1:0]    mode;
    logic          coef_wr_en;
    logic [AW-1:0] coef_addr;
    logic [CW-1:0] coef_data;
    logic [DW-1:0] y;
    logic          y_valid;
    logic          busy;
    logic          overrun;
    logic          sat;

    always #5 clk = ~clk;

    halfband_interp_mac_n #(.DATA_W(DW), .COEF_W(CW), .NUM_PAIRS(NP), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset), .sam_clk_en(sam_clk_en), .bit_rate_en(bit_rate_en),
        .x_in(x_in), .mode(mode), .coef_wr_en(coef_wr_en), .coef_addr(coef_addr),
        .coef_data(coef_data), .y(y), .y_valid(y_valid), .busy(busy),
        .overrun(overrun), .sat(sat)
    );

    int n_chk = 0;
    int n_bad = 0;

    // Reference model: sample history, coefficient banks and a pending result with a countdown.
    int hist [2*NP];
    int shad [NP];
    int act  [NP];
    int res_m, pend_m, cnt_m, y_m;
    bit yv_m, ovr_m, sat_m, ph_m, pend_sat, busy_m;

    bit chk_en = 1'b0;
    bit cap_en = 1'b0;
    int cap_q[$];
    int s1_exp[10] = '{0, -2305, 0, 18730, 32768, 18730, 0, -2305, 0, 0};

    task automatic check(input string nm, input logic signed [31:0] a, input int e);
        n_chk++;
        if (a !== e) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
        end
    endtask

    function automatic void eval_mac(output int r, output bit s);
        longint full;
        int     p;
        full = 0;
        for (int k = 0; k < NP; k++) begin
            p = (hist[NP-1-k] >>> 1) + (hist[NP+k] >>> 1);
            full += longint'(act[k]) * longint'(p);
        end
        full = full >>> (CW - 1);
        if (full > YMAX) begin
            r = YMAX; s = 1'b1;
        end else if (full < YMIN) begin
            r = YMIN; s = 1'b1;
        end else begin
            r = int'(full); s = 1'b0;
        end
    endfunction

    task automatic model_step();
        int old;
        if (reset) begin
            for (int i = 0; i < 2*NP; i++) hist[i] = 0;
            for (int k = 0; k < NP; k++) begin shad[k] = 0; act[k] = 0; end
            res_m = 0; pend_m = 0; cnt_m = 0; y_m = 0;
            yv_m = 0; ovr_m = 0; sat_m = 0; ph_m = 0; pend_sat = 0; busy_m = 0;
        end else begin
            if (sam_clk_en) begin
                for (int i = 2*NP-1; i > 0; i--) hist[i] = hist[i-1];
                hist[0] = int'($signed(x_in));
                for (int k = 0; k < NP; k++) act[k] = shad[k];
                ph_m = 1'b0;
            end
            if (coef_wr_en && (int'(coef_addr) < NP)) shad[coef_addr] = int'($signed(coef_data));
            yv_m = bit_rate_en;
            if (bit_rate_en) begin
                case (mode)
                    2'b00:   y_m = ph_m ? res_m : (hist[NP] >>> 1);
                    2'b01:   y_m = ph_m ? 0 : hist[NP];
                    2'b10:   y_m = hist[NP];
                    default: y_m = 0;
                endcase
                ph_m = !ph_m;
            end
            old = cnt_m;
            if (old == 1) begin
                res_m = pend_m;
                if (pend_sat) sat_m = 1'b1;
            end
            if (sam_clk_en) begin
                if (old >= 2) ovr_m = 1'b1;
                eval_mac(pend_m, pend_sat);
                cnt_m = NP + 1;
            end else if (old > 0) begin
                cnt_m = old - 1;
            end
            busy_m = (cnt_m >= 2);
        end
    endtask

    always @(posedge clk or posedge reset) model_step();

    // Per-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("y", $signed(y), y_m);
            check("y_valid", y_valid, int'(yv_m));
            check("busy", busy, int'(busy_m));
            check("overrun", overrun, int'(ovr_m));
            check("sat", sat, int'(sat_m));
        end
    end

    always @(negedge clk) begin
        if (cap_en && y_valid) cap_q.push_back(int'($signed(y)));
    end

    task automatic cyc(input bit s, input bit b);
        sam_clk_en  = s;
        bit_rate_en = b;
        @(posedge clk);
        #1;
        sam_clk_en  = 1'b0;
        bit_rate_en = 1'b0;
        coef_wr_en  = 1'b0;
    endtask

    task automatic wr(input int a, input int d);
        coef_wr_en = 1'b1;
        coef_addr  = AW'(a);
        coef_data  = CW'(d);
        cyc(1'b0, 1'b0);
    endtask

    // One input sample: 8 clk, bit_rate_en every 4 clk, optional coefficient write at clk wr_at.
    task automatic sample(input int xv, input int wr_at, input int wa, input int wd);
        x_in = DW'(xv);
        for (int i = 0; i < 8; i++) begin
            if (i == wr_at) begin
                coef_wr_en = 1'b1;
                coef_addr  = AW'(wa);
                coef_data  = CW'(wd);
            end
            cyc(i == 0, (i == 0) || (i == 4));
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        reset = 1'b0;
        cyc(1'b0, 1'b0);
    endtask

    task automatic impulse_check(input string tag);
        cap_q.delete();
        cap_en = 1'b1;
        sample(65536, -1, 0, 0);
        repeat (4) sample(0, -1, 0, 0);
        cap_en = 1'b0;
        check({tag, "_len"}, cap_q.size(), 10);
        for (int i = 0; i < 10; i++) begin
            if (i < cap_q.size()) check($sformatf("%s_y%0d", tag, i), cap_q[i], s1_exp[i]);
        end
        check({tag, "_sat"}, sat, 0);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    initial begin
        reset = 1'b1; sam_clk_en = 1'b0; bit_rate_en = 1'b0; x_in = '0; mode = 2'b00;
        coef_wr_en = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (3) @(posedge clk);
        #1;
        chk_en = 1'b1;
        check("rst_y", $signed(y), 0);
        check("rst_yv", y_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_ovr", overrun, 0);
        check("rst_sat", sat, 0);
        reset = 1'b0;
        cyc(1'b0, 1'b0);

        // Impulse response.
        wr(0, 74920);
        wr(1, -9220);
        impulse_check("s1");

        // Full-scale DC saturates both ways.
        wr(0, 131071);
        wr(1, 131071);
        repeat (4) sample(131071, -1, 0, 0);
        cap_q.delete(); cap_en = 1'b1;
        sample(131071, -1, 0, 0);
        cap_en = 1'b0;
        check("s2_len", cap_q.size(), 2);
        if (cap_q.size() == 2) begin
            check("s2_pos_ph0", cap_q[0], 65535);
            check("s2_pos_ph1", cap_q[1], 131071);
        end
        check("s2_sat", sat, 1);
        repeat (4) sample(-131072, -1, 0, 0);
        cap_q.delete(); cap_en = 1'b1;
        sample(-131072, -1, 0, 0);
        cap_en = 1'b0;
        if (cap_q.size() == 2) check("s2_neg_ph1", cap_q[1], -131072);
        else check("s2_neg_len", cap_q.size(), 2);

        // Coefficient rewrite in the middle of a MAC.
        do_reset();
        wr(0, 74920);
        wr(1, -9220);
        sample(65536, -1, 0, 0);
        cap_q.delete(); cap_en = 1'b1;
        sample(0, 2, 0, 0);
        sample(0, -1, 0, 0);
        cap_en = 1'b0;
        check("s3_len", cap_q.size(), 4);
        if (cap_q.size() == 4) begin
            check("s3_cur_ph1", cap_q[1], 18730);
            check("s3_nxt_ph0", cap_q[2], 32768);
            check("s3_nxt_ph1", cap_q[3], 0);
        end

        // Bypass and mute modes.
        mode = 2'b01;
        repeat (3) sample(1000, -1, 0, 0);
        for (int m = 1; m < 4; m++) begin
            mode = 2'(m);
            cap_q.delete(); cap_en = 1'b1;
            sample(1000, -1, 0, 0);
            cap_en = 1'b0;
            check($sformatf("s4_m%0d_len", m), cap_q.size(), 2);
            if (cap_q.size() == 2) begin
                check($sformatf("s4_m%0d_ph0", m), cap_q[0], (m == 3) ? 0 : 1000);
                check($sformatf("s4_m%0d_ph1", m), cap_q[1], (m == 2) ? 1000 : 0);
            end
        end

        // Overrun: second sam_clk_en two clk after the first.
        mode = 2'b00;
        do_reset();
        wr(0, 74920);
        wr(1, -9220);
        sample(65536, -1, 0, 0);
        x_in = '0;
        cap_q.delete(); cap_en = 1'b1;
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        check("s5_ovr_before", overrun, 0);
        cyc(1'b1, 1'b1);
        check("s5_ovr", overrun, 1);
        check("s5_busy_a", busy, 1);
        cyc(1'b0, 1'b1);
        check("s5_busy_b", busy, 1);
        cyc(1'b0, 1'b0);
        cap_en = 1'b0;
        check("s5_len", cap_q.size(), 3);
        if (cap_q.size() == 3) begin
            check("s5_c0", cap_q[0], 0);
            check("s5_c1", cap_q[1], 32768);
            check("s5_kept_result", cap_q[2], -2305);
        end
        repeat (6) cyc(1'b0, 1'b0);

        // Asynchronous reset in the middle of a MAC.
        x_in = DW'(65536);
        cyc(1'b1, 1'b1);
        cyc(1'b0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        check("s6_y", $signed(y), 0);
        check("s6_yv", y_valid, 0);
        check("s6_busy", busy, 0);
        check("s6_ovr", overrun, 0);
        check("s6_sat", sat, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        cyc(1'b0, 1'b0);
        cap_q.delete(); cap_en = 1'b1;
        sample(65536, -1, 0, 0);
        cap_en = 1'b0;
        if (cap_q.size() == 2) check("s6_coef_zero", cap_q[1], 0);
        else check("s6_len", cap_q.size(), 2);
        do_reset();
        wr(0, 74920);
        wr(1, -9220);
        impulse_check("s6");

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 150; n++) begin
            int xv;
            int wd;
            xv = int'($urandom_range(0, 2**DW - 1)) - 2**(DW-1);
            if ($urandom_range(0, 1) == 1) wd = int'($urandom_range(0, 2**CW - 1)) - 2**(CW-1);
            else wd = int'($urandom_range(0, 40000)) - 20000;
            mode = 2'($urandom_range(0, 3));
            sample(xv, int'($urandom_range(0, 11)), int'($urandom_range(0, 1)), wd);
        end

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
